clk_switch_ctrl: RTL and testbench

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

---
 rtl/clk_switch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock source switch controller: sequences the AND-gate enables of two
// clock sources through disable, dead-time guard and enable, using synchronized acks.
module clk_switch_ctrl #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   GUARD_CYCLES = 4,
  parameter int   TIMEOUT      = 255,
  parameter logic DEFAULT_SEL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_sel,
  output logic       req_ready,
  input  logic       ack0,
  input  logic       ack1,
  output logic       en0,
  output logic       en1,
  output logic       cur_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIS_OLD = 3'd1,
    GUARD   = 3'd2,
    EN_NEW  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_sel is sampled on that edge only, and req_valid without req_ready is dropped.

  state_t                 state_q, state_d;
  logic                   cur_q, cur_d;
  logic                   target_q, target_d;
  logic                   en0_q, en0_d;
  logic                   en1_q, en1_d;
  logic                   done_q, done_d;
  logic [CW-1:0]          wait_q, wait_d;
  logic [3:0]             guard_q, guard_d;
  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;

  logic          s_ack0, s_ack1, s_ack_cur, s_ack_tgt;
  logic          wait_hit;
  logic [CW-1:0] wait_inc;

  assign s_ack0    = sync0_q[SYNC_STAGES-1];
  assign s_ack1    = sync1_q[SYNC_STAGES-1];
  assign s_ack_cur = cur_q    ? s_ack1 : s_ack0;
  assign s_ack_tgt = target_q ? s_ack1 : s_ack0;

  // Counter saturates at TIMEOUT; the wait state is left after exactly TIMEOUT cycles.
  assign wait_hit = (wait_q >= CW'(TIMEOUT - 1));
  assign wait_inc = (wait_q >= CW'(TIMEOUT)) ? wait_q : wait_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], ack0};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], ack1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= DEFAULT_SEL;
      target_q <= DEFAULT_SEL;
      en0_q    <= ~DEFAULT_SEL;
      en1_q    <= DEFAULT_SEL;
      done_q   <= 1'b0;
      wait_q   <= '0;
      guard_q  <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      en0_q    <= en0_d;
      en1_q    <= en1_d;
      done_q   <= done_d;
      wait_q   <= wait_d;
      guard_q  <= guard_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    target_d = target_q;
    en0_d    = en0_q;
    en1_d    = en1_q;
    done_d   = 1'b0;
    wait_d   = wait_q;
    guard_d  = guard_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_sel == cur_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_sel;
            state_d  = DIS_OLD;
            en0_d    = 1'b0;
            en1_d    = 1'b0;
            wait_d   = '0;
          end
        end
      end
      DIS_OLD: begin
        wait_d = wait_inc;
        if (!s_ack_cur) begin
          state_d = GUARD;
          guard_d = '0;
        end else if (wait_hit) begin
          state_d = ERROR;
        end
      end
      GUARD: begin
        guard_d = guard_q + 1'b1;
        if (guard_q == 4'(GUARD_CYCLES - 1)) begin
          state_d = EN_NEW;
          en0_d   = ~target_q;
          en1_d   = target_q;
          wait_d  = '0;
        end
      end
      EN_NEW: begin
        wait_d = wait_inc;
        if (s_ack_tgt) begin
          state_d = IDLE;
          cur_d   = target_q;
          done_d  = 1'b1;
        end else if (wait_hit) begin
          state_d = ERROR;
          en0_d   = 1'b0;
          en1_d   = 1'b0;
        end
      end
      ERROR: begin
        en0_d = 1'b0;
        en1_d = 1'b0;
        if (req_valid) begin
          target_d = req_sel;
          state_d  = DIS_OLD;
          wait_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign en0       = en0_q;
  assign en1       = en1_q;
  assign cur_sel   = cur_q;
  assign done      = done_q;
  assign req_ready = (state_q == IDLE) || (state_q == ERROR);
  assign busy      = (state_q == DIS_OLD) || (state_q == GUARD) || (state_q == EN_NEW);
  assign err       = (state_q == ERROR);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: gating stages modeled as acks following enables by one cycle,
// table of switch requests plus sequences for timeout, ignored requests and reset abort.
module tb_clk_switch_ctrl;

  localparam int GUARD_CYCLES = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int TIMEOUT      = 255;
  localparam int LAT_NOM      = 1 + SYNC_STAGES + GUARD_CYCLES + 1 + SYNC_STAGES;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_sel = 1'b0;
  logic ack0 = 1'b1, ack1 = 1'b0;
  logic kill0 = 1'b0, kill1 = 1'b0;
  logic req_ready, en0, en1, cur_sel, busy, done, err;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic sel;
    logic exp_cur;
    logic exp_en0;
    logic exp_en1;
    logic is_sw;
  } vec_t;

  clk_switch_ctrl #(
    .SYNC_STAGES(SYNC_STAGES), .GUARD_CYCLES(GUARD_CYCLES),
    .TIMEOUT(TIMEOUT), .DEFAULT_SEL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .ack0(ack0), .ack1(ack1), .en0(en0), .en1(en1),
    .cur_sel(cur_sel), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---- clock / reset / gating-stage model ----
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ack0 <= en0 & ~kill0;
    ack1 <= en1 & ~kill1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---- scoreboard and safety monitor ----
  always @(negedge clk) begin
    total++;
    if (en0 === 1'b1 && en1 === 1'b1) begin
      bad++;
      $display("FAIL en_exclusive: got en0=%b en1=%b required never both 1", en0, en1);
    end
    if (done === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: got done with cur_sel=%b expected none", cur_sel);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        if (cur_sel !== e) begin
          bad++;
          $display("FAIL sb_cur_sel: got %b expected %b", cur_sel, e);
        end
      end
    end
  end

  // ---- driver tasks ----
  task automatic send_req(input logic sel, input logic expect_done);
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = sel;
    if (expect_done) exp_q.push_back(sel);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_switch(input logic sel, input logic old_sel, output int lat,
                           output int both_low, output logic old_en_k1,
                           output logic saw_busy, output logic got);
    send_req(sel, 1'b1);
    lat = -1; both_low = 0; saw_busy = 1'b0; got = 1'b0;
    old_en_k1 = old_sel ? en1 : en0;
    for (int k = 1; k <= 60; k++) begin
      if (busy) saw_busy = 1'b1;
      if (!en0 && !en1) both_low++;
      if (done) begin
        lat = k - 1;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int limit, output logic got);
    got = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---- test sequence ----
  initial begin
    vec_t vt[7];
    logic cur_model;
    int   lat, both_low, en1_cycles, done_cnt;
    logic old_en, saw_busy, got, seen;

    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_en0", en0, 1);
    check("rst_en1", en1, 0);
    check("rst_cur_sel", cur_sel, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // table of requests: same-source completes next cycle, switches run the full sequence
    cur_model = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_switch(vt[i].sel, cur_model, lat, both_low, old_en, saw_busy, got);
      check($sformatf("v%0d_done_seen", i), got, 1);
      check($sformatf("v%0d_cur_sel", i), cur_sel, vt[i].exp_cur);
      check($sformatf("v%0d_en0", i), en0, vt[i].exp_en0);
      check($sformatf("v%0d_en1", i), en1, vt[i].exp_en1);
      check($sformatf("v%0d_busy_seen", i), saw_busy, vt[i].is_sw);
      if (vt[i].is_sw) begin
        check($sformatf("v%0d_old_en_off", i), old_en, 0);
        check($sformatf("v%0d_guard_low", i), both_low >= GUARD_CYCLES, 1);
        check($sformatf("v%0d_lat_in_range lat=%0d", i, lat),
              (lat >= LAT_NOM - 2) && (lat <= LAT_NOM + 2), 1);
      end else begin
        check($sformatf("v%0d_old_en_kept", i), old_en, 1);
        check($sformatf("v%0d_lat", i), lat, 0);
      end
      cur_model = vt[i].exp_cur;
      repeat (2) @(negedge clk);
    end

    // ack activity while idle has no effect
    kill0 = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_ack_en0", en0, 1);
    check("idle_ack_busy", busy, 0);
    check("idle_ack_err", err, 0);
    kill0 = 1'b0;
    repeat (4) @(negedge clk);

    // dead new source: EN_NEW times out into ERROR
    kill1 = 1'b1;
    send_req(1'b1, 1'b0);
    en1_cycles = 0;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (en1) en1_cycles++;
      if (err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("to_err_seen", seen, 1);
    check("to_en_new_cycles", en1_cycles, TIMEOUT);
    check("to_en0", en0, 0);
    check("to_en1", en1, 0);
    check("to_cur_sel", cur_sel, 0);
    check("to_req_ready", req_ready, 1);
    check("to_busy", busy, 0);
    kill1 = 1'b0;
    repeat (3) @(negedge clk);

    // recovery from ERROR with a healthy source
    send_req(1'b0, 1'b1);
    check("rec_err_cleared", err, 0);
    wait_done(60, got);
    check("rec_done_seen", got, 1);
    check("rec_cur_sel", cur_sel, 0);
    check("rec_en0", en0, 1);
    check("rec_en1", en1, 0);
    check("rec_err", err, 0);
    repeat (3) @(negedge clk);

    // opposite request while in GUARD is ignored
    send_req(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("grd_both_low", {en0, en1}, 0);
    check("grd_not_ready", req_ready, 0);
    req_valid = 1'b1;
    req_sel   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("grd_done_count", done_cnt, 1);
    check("grd_cur_sel", cur_sel, 1);
    check("grd_en1", en1, 1);
    check("grd_en0", en0, 0);

    // reset during EN_NEW aborts the switch immediately
    do_switch(1'b0, 1'b1, lat, both_low, old_en, saw_busy, got);
    check("pre_rst_cur_sel", cur_sel, 0);
    repeat (2) @(negedge clk);
    send_req(1'b1, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (en1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_en_new_reached", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en0", en0, 1);
    check("arst_en1", en1, 0);
    check("arst_busy", busy, 0);
    check("arst_cur_sel", cur_sel, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_err", err, 0);
    check("arst_pending", exp_q.size(), 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_en0", en0, 1);
    check("post_rst_en1", en1, 0);
    check("post_rst_cur_sel", cur_sel, 0);
    check("post_rst_busy", busy, 0);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
